cv_ctrl_encoder: RTL

CV_CTRL_ENCODER -- requirements
Module: cv_ctrl_encoder

---
 rtl/cv_ctrl_encoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/cv_ctrl_encoder.sv
// Console controller port encoder: keypad/joystick segment mux onto active-low
// data lines, plus a saturating spinner accumulator driving quadrature outputs.
module cv_ctrl_encoder #(
  parameter int NUM_PORTS = 2,
  parameter int SPIN_W    = 8,
  parameter int STEP_DIV  = 512
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce,
  input  logic [NUM_PORTS*20-1:0]       joy_i,
  input  logic [NUM_PORTS*SPIN_W-1:0]   spin_i,
  input  logic [NUM_PORTS-1:0]          spin_stb_i,
  input  logic [NUM_PORTS-1:0]          spin_en_i,
  input  logic [NUM_PORTS-1:0]          sel_kp_n_i,
  input  logic [NUM_PORTS-1:0]          sel_joy_n_i,
  output logic [NUM_PORTS-1:0]          ctrl_p1_o,
  output logic [NUM_PORTS-1:0]          ctrl_p2_o,
  output logic [NUM_PORTS-1:0]          ctrl_p3_o,
  output logic [NUM_PORTS-1:0]          ctrl_p4_o,
  output logic [NUM_PORTS-1:0]          ctrl_p6_o,
  output logic [NUM_PORTS-1:0]          ctrl_p7_o,
  output logic [NUM_PORTS-1:0]          ctrl_p9_o
);

  localparam int ACC_W = SPIN_W + 2;
  localparam int SUM_W = ACC_W + 2;
  localparam int TMR_W = $clog2(STEP_DIV);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_HI  = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0] SAT_LO  = SUM_W'(ACC_MIN);

  // {p1,p2,p3,p4} codes for keys 0..9, '*', '#', purple, blue (index = joy bit)
  localparam logic [3:0] KP_LUT [14] = '{
    4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001, 4'b1001, 4'b0111,
    4'b1100, 4'b1000, 4'b1011, 4'b1010, 4'b0101, 4'b0100, 4'b0010
  };

  logic [TMR_W-1:0] timer;
  logic             timer_tc;
  logic             step;

  assign timer_tc = (timer == TMR_W'(STEP_DIV - 1));
  assign step     = ce & timer_tc;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      timer <= '0;
    end else if (ce) begin
      timer <= timer_tc ? '0 : timer + 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    logic [19:0]               pad;
    logic [3:0]                kp_nib;
    logic [3:0]                joy_nib;
    logic                      kp_p6;
    logic                      joy_p6;
    logic signed [SPIN_W-1:0]  spin_s;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [SUM_W-1:0]   sum;
    logic signed [SUM_W-1:0]   delta;
    logic signed [SUM_W-1:0]   dec;
    logic signed [1:0]         dir;
    logic [1:0]                phase;
    logic [1:0]                phase_nxt;
    logic [6:0]                out_q;

    assign pad    = joy_i[n*20 +: 20];
    assign spin_s = $signed(spin_i[n*SPIN_W +: SPIN_W]);

    always_comb begin
      kp_nib  = 4'hF;
      kp_p6   = 1'b1;
      joy_nib = 4'hF;
      joy_p6  = 1'b1;
      if (!sel_kp_n_i[n]) begin
        kp_p6 = ~pad[19];
        // scan downward so the lowest-numbered pressed key wins
        for (int k = 13; k >= 0; k--) begin
          if (pad[k]) kp_nib = KP_LUT[k];
        end
      end
      if (!sel_joy_n_i[n]) begin
        joy_nib = ~{pad[14], pad[15], pad[16], pad[17]};
        joy_p6  = ~pad[18];
      end
    end

    always_comb begin
      dir = 2'sd0;
      if (acc[ACC_W-1])
        dir = -2'sd1;
      else if (|acc)
        dir = 2'sd1;

      delta = '0;
      if (spin_stb_i[n]) delta = SUM_W'(spin_s);
      dec = '0;
      if (step) dec = SUM_W'(dir);
      sum = SUM_W'(acc) + delta - dec;

      if (sum > SAT_HI)
        acc_nxt = ACC_MAX;
      else if (sum < SAT_LO)
        acc_nxt = ACC_MIN;
      else
        acc_nxt = ACC_W'(sum);

      phase_nxt = phase;
      if (step) begin
        if (dir == 2'sd1)
          phase_nxt = phase + 2'd1;
        else if (dir == -2'sd1)
          phase_nxt = phase - 2'd1;
      end

      if (!spin_en_i[n]) begin
        acc_nxt   = '0;
        phase_nxt = 2'd0;
      end
    end

    // out_q = {p1,p2,p3,p4,p6,p7,p9}; quadrature is Gray-coded from phase
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        acc   <= '0;
        phase <= 2'd0;
        out_q <= '1;
      end else if (ce) begin
        acc   <= acc_nxt;
        phase <= phase_nxt;
        out_q <= {kp_nib & joy_nib, kp_p6 & joy_p6,
                  ~phase_nxt[1], ~(phase_nxt[1] ^ phase_nxt[0])};
      end
    end

    assign ctrl_p1_o[n] = out_q[6];
    assign ctrl_p2_o[n] = out_q[5];
    assign ctrl_p3_o[n] = out_q[4];
    assign ctrl_p4_o[n] = out_q[3];
    assign ctrl_p6_o[n] = out_q[2];
    assign ctrl_p7_o[n] = out_q[1];
    assign ctrl_p9_o[n] = out_q[0];
  end

endmodule
